ea_inscan: RTL and testbench
============================

Name: ea_inscan

Overview:
- Sequencer for the EA4163 input channels 1-24.
- Steps the shared 3-bit input multiplexer address over channels 0..7. Drives the three bank enables with break-before-make and a settle time. Samples I_M_1_8_IN / I_M_9_16_IN / I_M_17_24_IN in parallel.
- Builds a 24-bit debounced input image, sticky change flags and an interrupt request.
- Sits between the VME register file (supplies the input enable, blocking mask, change-clear strobes and IRQ enable) and the board multiplexers.

Parameters:
- SETTLE_CYC, 16, clocks the enables are held with a stable address before sampling (legal range 1..255).
- FW, 8, frame counter width.

Ports:
- I_CLK_32M  in  1  system clock, 32 MHz.
- I_VME_SYSRESET_N  in  1  asynchronous active-low reset.
- I_SCAN_EN  in  1  scan enable (input-channel enable from the command decoder).
- I_BLCKIN  in  24  per-channel pass mask; 1 = channel used, 0 = blocked.
- I_IRQ_EN  in  1  interrupt enable.
- I_CHG_CLR  in  24  one-cycle write-1-to-clear strobes for O_CHG.
- I_M_1_8_IN  in  1  bank 1 multiplexer output.
- I_M_9_16_IN  in  1  bank 2 multiplexer output.
- I_M_17_24_IN  in  1  bank 3 multiplexer output.
- O_MUX_A  out  3  multiplexer address, equal to the channel index within a bank.
- O_MUX_1_8_EN  out  1  bank 1 enable, active high.
- O_MUX_9_16_EN  out  1  bank 2 enable, active high.
- O_MUX_17_24_EN  out  1  bank 3 enable, active high.
- O_IN_DATA  out  24  debounced, masked input image; bit n = channel n+1.
- O_CHG  out  24  sticky change flags.
- O_IN_VALID  out  1  one-cycle pulse when a frame is committed.
- O_IRQ  out  1  interrupt request, level.
- O_BUSY  out  1  scan in progress.
- O_FRAME_CNT  out  FW  committed frame count; wraps modulo 2^FW.

Behaviour:
- Reset (asynchronous, I_VME_SYSRESET_N=0):
  - State = IDLE.
  - O_MUX_A=0, all three enables=0.
  - O_IN_DATA=0, shadow and previous shadow = 0.
  - O_CHG=0, O_IN_VALID=0, O_IRQ=0, O_BUSY=0, O_FRAME_CNT=0.
  - Deasserting reset mid-frame restarts from IDLE.
- FSM states: IDLE, ADDR, SETTLE, SAMPLE, DONE.
  - IDLE: enables=0, O_MUX_A=0. If I_SCAN_EN=1, go to ADDR with ch=0.
  - ADDR (1 cycle): O_MUX_A<=ch, enables=0 (break-before-make). Go to SETTLE and load the counter with SETTLE_CYC-1.
  - SETTLE (SETTLE_CYC cycles): all three enables=1; the counter decrements. When the counter reaches 0, go to SAMPLE.
  - SAMPLE (1 cycle, enables still 1): at the end of the cycle capture shadow[ch]=I_M_1_8_IN, shadow[8+ch]=I_M_9_16_IN, shadow[16+ch]=I_M_17_24_IN.
    - If I_SCAN_EN=0: go to IDLE; the partial frame is discarded and O_IN_DATA is held.
    - Else if ch=7: go to DONE.
    - Else: ch<=ch+1 and go to ADDR.
  - DONE (1 cycle, enables=0): commit the frame and pulse O_IN_VALID. Go to ADDR with ch=0 if I_SCAN_EN=1, else go to IDLE.
- Frame period: 8*(SETTLE_CYC+2)+1 cycles, which is 145 for the default.
- O_BUSY=1 in every state except IDLE.
- Commit (in DONE), per bit n:
  - If I_BLCKIN[n]=0: new[n]=0.
  - Else if shadow[n]==prev[n]: new[n]=shadow[n].
  - Else: new[n]=O_IN_DATA[n]. A value must match over two consecutive frames to be accepted.
  - Then prev<=shadow, O_IN_DATA<=new, O_FRAME_CNT<=O_FRAME_CNT+1.
- O_CHG[n] is set in DONE when new[n]!=O_IN_DATA[n] and I_BLCKIN[n]=1.
  - O_CHG[n] is cleared when I_CHG_CLR[n]=1.
  - Set and clear in the same cycle: set wins.
- O_IRQ is registered: I_IRQ_EN & |(O_CHG & I_BLCKIN). It updates one cycle after O_CHG.
- Masking a channel (I_BLCKIN falls): O_IN_DATA for that bit goes to 0 at the next commit. O_CHG is not set for it; an already-set flag stays until cleared.
- I_SCAN_EN changes while in ADDR or SETTLE: the FSM continues to SAMPLE and the abort is evaluated there.

Decomposition:
- Shared package ea_pkg holds:
  - state enum (IDLE, ADDR, SETTLE, SAMPLE, DONE);
  - NCH_BANK=8, NBANK=3, NCH=24;
  - default SETTLE_CYC.
- One sub-module, ea_inscan_filt: holds prev/shadow, performs the per-bit debounce and mask on commit, and drives O_IN_DATA and O_CHG set/clear.
- ea_inscan keeps the FSM, counters and mux drive.

Test Plan:
- Reset, then I_SCAN_EN=1, SETTLE_CYC=16, all inputs 0:
  - O_MUX_A steps 0..7 with a 1-cycle enable gap before each step.
  - O_IN_VALID pulses every 145 cycles.
  - O_FRAME_CNT=1,2,...; O_IN_DATA=0.
- I_BLCKIN=24'hFFFFFF; I_M_9_16_IN=1 only while O_MUX_A=3:
  - After frame 1, O_IN_DATA=0.
  - After frame 2, O_IN_DATA=24'h000800 and O_CHG=24'h000800.
  - With I_IRQ_EN=1, O_IRQ=1 one cycle later.
- A single-frame glitch on channel 17 (bank 3, addr 0):
  - O_IN_DATA is unchanged and O_CHG[16] stays 0.
- I_CHG_CLR=24'h000800 pulsed in the same cycle a commit sets O_CHG[11]:
  - O_CHG[11] remains 1.
  - A later lone clear gives O_CHG=0 and O_IRQ=0.
- I_BLCKIN[11]=0 while the channel-12 input stays 1:
  - At the next commit, O_IN_DATA[11]=0 and O_CHG[11] is not set.
- I_SCAN_EN dropped during SETTLE of ch=5:
  - The FSM finishes SAMPLE, then IDLE; enables=0, O_MUX_A=0, no O_IN_VALID, O_IN_DATA held.
  - Asynchronous reset asserted mid-SETTLE: all outputs are 0 immediately.

Source files
------------

// File: rtl/ea_inscan_pkg.sv
// Shared definitions for the EA4163 input-channel scanner.
//   state_t        : scan sequencer states
//   NCH_BANK/NBANK : channels per multiplexer bank and number of banks
//   NCH            : total input channels
//   SETTLE_CYC_DEF : default settle time in clocks
package ea_pkg;

  localparam int NCH_BANK       = 8;
  localparam int NBANK          = 3;
  localparam int NCH            = NCH_BANK * NBANK;
  localparam int SETTLE_CYC_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/ea_inscan_filt.sv
// Input image filter for the scanner.
// Collects one frame of samples into a shadow register, then on commit
// applies a two-frame debounce and the channel pass mask, and maintains
// the sticky change flags.
//   clk, rst_n : clock, asynchronous active-low reset
//   sample     : capture bank_in into shadow at channel ch this cycle
//   commit     : frame complete; update prev, in_data and chg
//   ch         : channel index within a bank
//   bank_in    : multiplexer outputs, bit b = bank b
//   blck       : pass mask, 1 = channel used
//   chg_clr    : write-1-to-clear strobes for chg
//   in_data    : debounced, masked input image
//   chg        : sticky change flags
module ea_inscan_filt
  import ea_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample,
  input  logic                commit,
  input  logic [2:0]          ch,
  input  logic [NBANK-1:0]    bank_in,
  input  logic [NCH-1:0]      blck,
  input  logic [NCH-1:0]      chg_clr,
  output logic [NCH-1:0]      in_data,
  output logic [NCH-1:0]      chg
);

  logic [NCH-1:0] shadow;
  logic [NCH-1:0] shadow_nxt;
  logic [NCH-1:0] prev;
  logic [NCH-1:0] diff;
  logic [NCH-1:0] new_data;
  logic [NCH-1:0] chg_set;

  // Each bank writes its bit at the same channel offset in parallel.
  always_comb begin
    shadow_nxt = shadow;
    for (int b = 0; b < NBANK; b++) begin
      for (int i = 0; i < NCH_BANK; i++) begin
        if (sample && (ch == 3'(i))) begin
          shadow_nxt[b*NCH_BANK + i] = bank_in[b];
        end
      end
    end
  end

  // A bit is accepted only when two consecutive frames agree; otherwise
  // the previously accepted value is kept. Blocked channels read as 0.
  assign diff     = shadow ^ prev;
  assign new_data = blck & ((shadow & ~diff) | (in_data & diff));
  assign chg_set  = {NCH{commit}} & blck & (new_data ^ in_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      prev    <= '0;
      in_data <= '0;
      chg     <= '0;
    end else begin
      shadow <= shadow_nxt;
      if (commit) begin
        prev    <= shadow;
        in_data <= new_data;
      end
      // Set has priority over a coincident clear.
      chg <= (chg & ~chg_clr) | chg_set;
    end
  end

endmodule

// File: rtl/ea_inscan.sv
// Scan sequencer for EA4163 input channels 1-24.
// Steps the shared mux address over 0..7, enables all three banks with
// break-before-make and a settle time, samples the three bank outputs in
// parallel and commits a debounced 24-bit image once per frame.
// Handshake: O_IN_VALID is a single-cycle pulse coincident with the first
// cycle in which O_IN_DATA, O_CHG and O_FRAME_CNT show the new frame; there
// is no back-pressure.
//   I_CLK_32M, I_VME_SYSRESET_N : clock, asynchronous active-low reset
//   I_SCAN_EN, I_BLCKIN, I_IRQ_EN, I_CHG_CLR : register-file controls
//   I_M_*_IN    : bank multiplexer outputs
//   O_MUX_A, O_MUX_*_EN : multiplexer address and bank enables
//   O_IN_DATA, O_CHG, O_IN_VALID, O_IRQ, O_BUSY, O_FRAME_CNT : status
//   dbg_state   : current sequencer state
module ea_inscan
  import ea_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int FW         = 8
) (
  input  logic            I_CLK_32M,
  input  logic            I_VME_SYSRESET_N,
  input  logic            I_SCAN_EN,
  input  logic [NCH-1:0]  I_BLCKIN,
  input  logic            I_IRQ_EN,
  input  logic [NCH-1:0]  I_CHG_CLR,
  input  logic            I_M_1_8_IN,
  input  logic            I_M_9_16_IN,
  input  logic            I_M_17_24_IN,
  output logic [2:0]      O_MUX_A,
  output logic            O_MUX_1_8_EN,
  output logic            O_MUX_9_16_EN,
  output logic            O_MUX_17_24_EN,
  output logic [NCH-1:0]  O_IN_DATA,
  output logic [NCH-1:0]  O_CHG,
  output logic            O_IN_VALID,
  output logic            O_IRQ,
  output logic            O_BUSY,
  output logic [FW-1:0]   O_FRAME_CNT,
  output state_t          dbg_state
);

  state_t     state, state_nxt;
  logic [2:0] ch, ch_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       sample;
  logic       commit;
  logic       bank_en;

  always_ff @(posedge I_CLK_32M or negedge I_VME_SYSRESET_N) begin
    if (!I_VME_SYSRESET_N) begin
      state       <= IDLE;
      ch          <= '0;
      cnt         <= '0;
      O_IN_VALID  <= 1'b0;
      O_IRQ       <= 1'b0;
      O_FRAME_CNT <= '0;
    end else begin
      state       <= state_nxt;
      ch          <= ch_nxt;
      cnt         <= cnt_nxt;
      O_IN_VALID  <= commit;
      O_IRQ       <= I_IRQ_EN & (|(O_CHG & I_BLCKIN));
      if (commit) begin
        O_FRAME_CNT <= O_FRAME_CNT + 1'b1;
      end
    end
  end

  // ch returns to 0 whenever the sequencer leaves a frame, so it can drive
  // the address directly: 0 in IDLE and already stable during ADDR while
  // the enables are off.
  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    cnt_nxt   = cnt;
    sample    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (I_SCAN_EN) begin
          state_nxt = ADDR;
          ch_nxt    = '0;
        end
      end
      ADDR: begin
        state_nxt = SETTLE;
        cnt_nxt   = 8'(SETTLE_CYC - 1);
      end
      SETTLE: begin
        if (cnt == 8'd0) begin
          state_nxt = SAMPLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      SAMPLE: begin
        sample = 1'b1;
        if (!I_SCAN_EN) begin
          state_nxt = IDLE;
          ch_nxt    = '0;
        end else if (ch == 3'd7) begin
          state_nxt = DONE;
        end else begin
          state_nxt = ADDR;
          ch_nxt    = ch + 3'd1;
        end
      end
      DONE: begin
        commit    = 1'b1;
        ch_nxt    = '0;
        state_nxt = I_SCAN_EN ? ADDR : IDLE;
      end
      default: begin
        state_nxt = IDLE;
        ch_nxt    = '0;
      end
    endcase
  end

  assign bank_en        = (state == SETTLE) || (state == SAMPLE);
  assign O_MUX_1_8_EN   = bank_en;
  assign O_MUX_9_16_EN  = bank_en;
  assign O_MUX_17_24_EN = bank_en;
  assign O_MUX_A        = ch;
  assign O_BUSY         = (state != IDLE);
  assign dbg_state      = state;

  ea_inscan_filt u_filt (
    .clk     (I_CLK_32M),
    .rst_n   (I_VME_SYSRESET_N),
    .sample  (sample),
    .commit  (commit),
    .ch      (ch),
    .bank_in ({I_M_17_24_IN, I_M_9_16_IN, I_M_1_8_IN}),
    .blck    (I_BLCKIN),
    .chg_clr (I_CHG_CLR),
    .in_data (O_IN_DATA),
    .chg     (O_CHG)
  );

endmodule

// File: tb/tb_ea_inscan.sv
`timescale 1ns/1ps
module tb_ea_inscan;
  import ea_pkg::*;

  logic        I_CLK_32M;
  logic        I_VME_SYSRESET_N;
  logic        I_SCAN_EN;
  logic [23:0] I_BLCKIN;
  logic        I_IRQ_EN;
  logic [23:0] I_CHG_CLR;
  logic        I_M_1_8_IN, I_M_9_16_IN, I_M_17_24_IN;
  logic [2:0]  O_MUX_A;
  logic        O_MUX_1_8_EN, O_MUX_9_16_EN, O_MUX_17_24_EN;
  logic [23:0] O_IN_DATA, O_CHG;
  logic        O_IN_VALID, O_IRQ, O_BUSY;
  logic [7:0]  O_FRAME_CNT;
  state_t      dbg_state;

  // Per-bank channel patterns; the mux model returns the bit at the address.
  logic [7:0] pat1, pat2, pat3;
  assign I_M_1_8_IN   = pat1[O_MUX_A];
  assign I_M_9_16_IN  = pat2[O_MUX_A];
  assign I_M_17_24_IN = pat3[O_MUX_A];

  ea_inscan dut (
    .I_CLK_32M        (I_CLK_32M),
    .I_VME_SYSRESET_N (I_VME_SYSRESET_N),
    .I_SCAN_EN        (I_SCAN_EN),
    .I_BLCKIN         (I_BLCKIN),
    .I_IRQ_EN         (I_IRQ_EN),
    .I_CHG_CLR        (I_CHG_CLR),
    .I_M_1_8_IN       (I_M_1_8_IN),
    .I_M_9_16_IN      (I_M_9_16_IN),
    .I_M_17_24_IN     (I_M_17_24_IN),
    .O_MUX_A          (O_MUX_A),
    .O_MUX_1_8_EN     (O_MUX_1_8_EN),
    .O_MUX_9_16_EN    (O_MUX_9_16_EN),
    .O_MUX_17_24_EN   (O_MUX_17_24_EN),
    .O_IN_DATA        (O_IN_DATA),
    .O_CHG            (O_CHG),
    .O_IN_VALID       (O_IN_VALID),
    .O_IRQ            (O_IRQ),
    .O_BUSY           (O_BUSY),
    .O_FRAME_CNT      (O_FRAME_CNT),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial I_CLK_32M = 1'b0;
  always #5 I_CLK_32M = ~I_CLK_32M;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  int exp_frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endtask

  task automatic wait_state(input state_t s, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge I_CLK_32M);
      if (dbg_state == s) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("wait_state");
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0]  p1, p2, p3;
    logic [23:0] blck, clr_done, clr_post, exp_data, exp_chg;
    logic        exp_irq;
  } vec_t;
  vec_t vt[11];

  initial begin
    bit ok;
    bit got;
    logic prev_en;
    logic [2:0] prev_mux;
    logic [2:0] rise_q[$];
    int gap_err, eq_err, cyc;
    bit saw_sample, saw_valid;
    logic [23:0] post_chg;

    //          p1     p2     p3     blck        clr_done    clr_post    data        chg         irq
    vt[0]  = '{8'h00, 8'h08, 8'h00, 24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 1'b0};
    vt[1]  = '{8'h00, 8'h08, 8'h00, 24'hFFFFFF, 24'h000000, 24'h000000, 24'h000800, 24'h000800, 1'b1};
    vt[2]  = '{8'h00, 8'h08, 8'h01, 24'hFFFFFF, 24'h000000, 24'h000000, 24'h000800, 24'h000800, 1'b1};
    vt[3]  = '{8'h00, 8'h08, 8'h00, 24'hFFFFFF, 24'h000000, 24'h000800, 24'h000800, 24'h000800, 1'b1};
    vt[4]  = '{8'h00, 8'h00, 8'h00, 24'hFFFFFF, 24'h000000, 24'h000000, 24'h000800, 24'h000000, 1'b0};
    vt[5]  = '{8'h00, 8'h00, 8'h00, 24'hFFFFFF, 24'h000800, 24'h000800, 24'h000000, 24'h000800, 1'b1};
    vt[6]  = '{8'h00, 8'h08, 8'h00, 24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 1'b0};
    vt[7]  = '{8'h00, 8'h08, 8'h00, 24'hFFFFFF, 24'h000000, 24'h000800, 24'h000800, 24'h000800, 1'b1};
    vt[8]  = '{8'h00, 8'h08, 8'h00, 24'hFFF7FF, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 1'b0};
    vt[9]  = '{8'hA5, 8'h08, 8'h3C, 24'hFFFFFF, 24'h000000, 24'h000000, 24'h000800, 24'h000800, 1'b1};
    vt[10] = '{8'hA5, 8'h08, 8'h3C, 24'hFFFFFF, 24'h000000, 24'h000000, 24'h3C08A5, 24'h3C08A5, 1'b1};

    I_VME_SYSRESET_N = 1'b0;
    I_SCAN_EN = 1'b0;
    I_BLCKIN  = 24'hFFFFFF;
    I_IRQ_EN  = 1'b0;
    I_CHG_CLR = '0;
    pat1 = '0; pat2 = '0; pat3 = '0;
    repeat (3) @(negedge I_CLK_32M);

    // ---- reset state ----
    check("rst_mux_a", 32'(O_MUX_A), 32'd0);
    check("rst_en", 32'({O_MUX_1_8_EN, O_MUX_9_16_EN, O_MUX_17_24_EN}), 32'd0);
    check("rst_data", 32'(O_IN_DATA), 32'd0);
    check("rst_misc", 32'({O_CHG, O_IN_VALID, O_IRQ, O_BUSY, O_FRAME_CNT}), 32'd0);
    I_VME_SYSRESET_N = 1'b1;
    @(negedge I_CLK_32M);
    check("idle_busy", 32'(O_BUSY), 32'd0);

    // ---- frame 1: address stepping and enable gaps ----
    I_SCAN_EN = 1'b1;
    prev_en = 1'b0; prev_mux = 3'd0; gap_err = 0; eq_err = 0; got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge I_CLK_32M);
      if (!(O_MUX_1_8_EN == O_MUX_9_16_EN && O_MUX_1_8_EN == O_MUX_17_24_EN)) eq_err++;
      if (O_MUX_A != prev_mux && O_MUX_1_8_EN) gap_err++;
      if (O_MUX_1_8_EN && !prev_en) rise_q.push_back(O_MUX_A);
      prev_en = O_MUX_1_8_EN;
      prev_mux = O_MUX_A;
      if (O_IN_VALID) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) timeout_fail("frame1");
    exp_frames++;
    check("enable_steps", 32'(rise_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < rise_q.size(); k++) check("step_addr", 32'(rise_q[k]), 32'(k));
    check("enable_equal_err", 32'(eq_err), 32'd0);
    check("addr_change_with_en", 32'(gap_err), 32'd0);
    check("f1_cnt", 32'(O_FRAME_CNT), 32'(exp_frames));
    check("f1_data", 32'(O_IN_DATA), 32'd0);
    check("f1_busy", 32'(O_BUSY), 32'd1);

    // ---- frame 2: period ----
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge I_CLK_32M);
      cyc++;
      if (O_IN_VALID) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) timeout_fail("frame2");
    exp_frames++;
    check("frame_period", 32'(cyc), 32'd145);
    check("f2_cnt", 32'(O_FRAME_CNT), 32'(exp_frames));
    check("f2_data", 32'(O_IN_DATA), 32'd0);

    // ---- table-driven frames ----
    I_IRQ_EN = 1'b1;
    foreach (vt[v]) begin
      pat1 = vt[v].p1; pat2 = vt[v].p2; pat3 = vt[v].p3;
      I_BLCKIN = vt[v].blck;
      exp_q.push_back(vt[v].exp_data);
      wait_state(DONE, 400, ok);
      I_CHG_CLR = vt[v].clr_done;
      @(negedge I_CLK_32M);
      I_CHG_CLR = '0;
      exp_frames++;
      check($sformatf("v%0d_valid", v), 32'(O_IN_VALID), 32'd1);
      check($sformatf("v%0d_data", v), 32'(O_IN_DATA), 32'(exp_q.pop_front()));
      check($sformatf("v%0d_chg", v), 32'(O_CHG), 32'(vt[v].exp_chg));
      check($sformatf("v%0d_cnt", v), 32'(O_FRAME_CNT), 32'(exp_frames[7:0]));
      @(negedge I_CLK_32M);
      check($sformatf("v%0d_irq", v), 32'(O_IRQ), 32'(vt[v].exp_irq));
      if (vt[v].clr_post != 24'h0) begin
        post_chg = vt[v].exp_chg & ~vt[v].clr_post;
        I_CHG_CLR = vt[v].clr_post;
        @(negedge I_CLK_32M);
        I_CHG_CLR = '0;
        check($sformatf("v%0d_chg_post", v), 32'(O_CHG), 32'(post_chg));
        @(negedge I_CLK_32M);
        check($sformatf("v%0d_irq_post", v), 32'(O_IRQ), 32'(|(post_chg & vt[v].blck)));
      end
    end

    // ---- IRQ enable gating ----
    I_IRQ_EN = 1'b0;
    @(negedge I_CLK_32M);
    check("irq_disabled", 32'(O_IRQ), 32'd0);
    I_IRQ_EN = 1'b1;
    @(negedge I_CLK_32M);
    check("irq_reenabled", 32'(O_IRQ), 32'd1);

    // ---- abort during SETTLE of ch=5 ----
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge I_CLK_32M);
      if (dbg_state == SETTLE && O_MUX_A == 3'd5) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) timeout_fail("settle_ch5");
    I_SCAN_EN = 1'b0;
    saw_sample = 1'b0; saw_valid = 1'b0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge I_CLK_32M);
      if (dbg_state == SAMPLE) saw_sample = 1'b1;
      if (O_IN_VALID) saw_valid = 1'b1;
      if (dbg_state == IDLE) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) timeout_fail("abort_idle");
    check("abort_saw_sample", 32'(saw_sample), 32'd1);
    check("abort_no_valid", 32'(saw_valid), 32'd0);
    check("abort_en", 32'({O_MUX_1_8_EN, O_MUX_9_16_EN, O_MUX_17_24_EN}), 32'd0);
    check("abort_mux_a", 32'(O_MUX_A), 32'd0);
    check("abort_busy", 32'(O_BUSY), 32'd0);
    check("abort_data_held", 32'(O_IN_DATA), 32'h3C08A5);
    check("abort_cnt_held", 32'(O_FRAME_CNT), 32'(exp_frames[7:0]));

    // ---- asynchronous reset mid-SETTLE ----
    I_SCAN_EN = 1'b1;
    wait_state(SETTLE, 40, ok);
    check("pre_rst_irq", 32'(O_IRQ), 32'd1);
    #2;
    I_VME_SYSRESET_N = 1'b0;
    #1;
    check("arst_mux_a", 32'(O_MUX_A), 32'd0);
    check("arst_en", 32'({O_MUX_1_8_EN, O_MUX_9_16_EN, O_MUX_17_24_EN}), 32'd0);
    check("arst_data", 32'(O_IN_DATA), 32'd0);
    check("arst_chg", 32'(O_CHG), 32'd0);
    check("arst_misc", 32'({O_IN_VALID, O_IRQ, O_BUSY, O_FRAME_CNT}), 32'd0);
    @(negedge I_CLK_32M);
    I_VME_SYSRESET_N = 1'b1;
    @(negedge I_CLK_32M);
    @(negedge I_CLK_32M);
    check("restart_busy", 32'(O_BUSY), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
